ysyx_wbu_arb: RTL
=================

Name: ysyx_wbu_arb

Overview:
- Writeback arbiter that shares the single ROB/PRF writeback port between NREQ execution units: ALU/branch, MUL/DIV and LSU/AMO.
- Each unit pushes results into a private small FIFO. A round-robin scheduler then drains exactly one result per cycle toward the ROB writeback port.
- Sits between the execute units and the re-order unit. A commit-time flush empties it.

Parameters:
- NREQ, 3, number of requesting execution units.
- DEPTH, 2, entries per requester FIFO; must be a power of two and at least 2.
- ROB_SIZE, `YSYX_ROB_SIZE, ROB entries. DW = $clog2(ROB_SIZE)+1 is the dest tag width; tag 0 is never issued.
- PLEN, `YSYX_PHY_LEN, physical register index width.
- XLEN, `YSYX_XLEN, datapath width.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous reset, active-low: reset==0 at a posedge resets the block.
- flush  in  1  pipeline flush from commit; sampled at posedge.
- req_valid  in  NREQ  per-unit result valid.
- req_ready  out  NREQ  per-unit FIFO not full.
- req_pkt  in  NREQ*$bits(wb_pkt_t)  per-unit result packet {dest, prd, wen, result, npc, trap, cause, tval}.
- wb_valid  out  1  result presented to the ROB port.
- wb_ready  in  1  ROB port accepts this cycle.
- wb_pkt  out  $bits(wb_pkt_t)  selected packet.
- wb_src  out  $clog2(NREQ)  index of the granted requester.

Behaviour:
- Reset (reset==0) and flush==1 behave identically at the posedge:
  - all FIFO pointers, counts and valid bits clear; RR pointer goes to 0.
  - any push or pop in that cycle is discarded.
  - a packet presented in the flush cycle is dropped even if req_ready was 1.
- After reset, and in any cycle where all FIFOs are empty: wb_valid=0, wb_src=0, wb_pkt=0 (zero-masked, not stale).
- Push: req_valid[i] && req_ready[i] writes FIFO i at the posedge.
  - req_ready[i] = (count[i] != DEPTH); it is registered-derived, with no combinational path from wb_ready.
  - A full FIFO does not accept in the cycle it pops.
- Arbitration is combinational over FIFO heads:
  - wb_valid = OR of FIFO non-empty flags.
  - The grant goes to the first non-empty requester scanning from rr_ptr upward, wrapping modulo NREQ.
  - wb_pkt and wb_src come from the granted head.
- Pop: wb_valid && wb_ready pops the granted FIFO at the posedge and sets rr_ptr = (grant+1) mod NREQ.
  - If there is no pop, rr_ptr holds.
  - The grant must stay stable while wb_ready==0: no re-arbitration, and the packet is held unchanged.
- Latency: a packet pushed at edge t is visible on wb_* in cycle t+1 at the earliest. There is no same-cycle bypass.
- Ordering: FIFO order is strict per requester; there is no ordering guarantee across requesters.
- Fairness: with all requesters continuously non-empty and wb_ready=1, each is granted exactly once every NREQ cycles.
- Simultaneous push and pop on the same non-full FIFO: count is unchanged and both pointers advance.
- Pointer wrap: rd/wr pointers are $clog2(DEPTH) bits and wrap naturally. The count is $clog2(DEPTH)+1 bits, which separates full from empty.
- Simulation-only assertions:
  - dest must never be 0 on push.
  - a push into a full FIFO is an error.

Decomposition:
- ysyx_pkg gains the typedef wb_pkt_t, with field order as listed under Ports.
- The NREQ encoding constants (WB_SRC_ALU=0, WB_SRC_MDU=1, WB_SRC_LSU=2) also go in ysyx_pkg.
- One sub-module, ysyx_wbu_fifo (DEPTH x wb_pkt_t; push/pop/full/empty/count; synchronous active-low reset plus a clear input), is instantiated NREQ times via generate.
- The round-robin priority scan stays inline in ysyx_wbu_arb.

Test Plan:
1. Single source: push ALU {dest=3, result=0xDEADBEEF} at cycle 0, wb_ready=1. Expect wb_valid=1, wb_src=0, dest=3 in cycle 1; wb_valid=0 in cycle 2.
2. Full contention: push into all three FIFOs every cycle for 12 cycles, wb_ready=1. Expect grant sequence 0,1,2,0,1,2… and exactly 4 grants per source.
3. Backpressure: hold wb_ready=0 for 5 cycles with MDU dest=7 granted. Expect wb_pkt/wb_src stable and LSU filling to req_ready[2]=0 after 2 pushes. Release, and 0 packets are lost or reordered.
4. Flush mid-operation: fill all FIFOs (6 entries), assert flush=1 for one cycle together with req_valid=3'b111. Next cycle: wb_valid=0, req_ready=3'b111, rr_ptr=0; pushed packets are absent.
5. Reset mid-operation: drive reset=0 for one cycle with 2 entries queued. Next cycle: wb_valid=0, wb_pkt=0, and the first new push of dest=1 appears after one cycle with wb_src correct.
6. Wrap and stable pointers: 100 push/pop pairs with a random pattern on LSU only at DEPTH=2. Expect the output dest sequence to match the input exactly and no req_ready drop while count<2.

Source files
------------

// File: rtl/ysyx_pkg.sv
// rtl/ysyx_pkg.sv - shared core types and widths for the writeback arbiter
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 32
`endif
`ifndef YSYX_PHY_LEN
`define YSYX_PHY_LEN 6
`endif
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

package ysyx_pkg;

    localparam int ROB_SIZE = `YSYX_ROB_SIZE;
    localparam int DW       = $clog2(ROB_SIZE) + 1;
    localparam int PLEN     = `YSYX_PHY_LEN;
    localparam int XLEN     = `YSYX_XLEN;
    localparam int CAUSE_W  = 5;

    // Requester encoding on wb_src
    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_MDU = 1;
    localparam int WB_SRC_LSU = 2;

    typedef struct packed {
        logic [DW-1:0]      dest;
        logic [PLEN-1:0]    prd;
        logic               wen;
        logic [XLEN-1:0]    result;
        logic [XLEN-1:0]    npc;
        logic               trap;
        logic [CAUSE_W-1:0] cause;
        logic [XLEN-1:0]    tval;
    } wb_pkt_t;

    localparam int WB_PKT_W = $bits(wb_pkt_t);

    // Packet width for a given set of core widths; matches $bits(wb_pkt_t) at the defaults.
    function automatic int wb_pkt_width(int rob_size, int plen, int xlen);
        return ($clog2(rob_size) + 1) + plen + 1 + 3 * xlen + 1 + CAUSE_W;
    endfunction

endpackage

// File: rtl/ysyx_wbu_fifo.sv
// rtl/ysyx_wbu_fifo.sv - per-requester result FIFO feeding the writeback arbiter
module ysyx_wbu_fifo
    import ysyx_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clock_i,
    input  logic                       resetn_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  wb_pkt_t                    pkt_i,
    input  logic                       pop_i,
    output wb_pkt_t                    head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_pkt_t         mem_q [DEPTH];
    logic [AW-1:0]   rd_q, rd_d;
    logic [AW-1:0]   wr_q, wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    // A full FIFO never accepts, even in a cycle where it also pops.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Reset and clear both drop every queued entry and any push/pop this cycle.
    always_ff @(posedge clock_i) begin
        if (!resetn_i || clear_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; stale contents are hidden behind the count.
    always_ff @(posedge clock_i) begin
        if (resetn_i && !clear_i && do_push) mem_q[wr_q] <= pkt_i;
    end

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clock_i) disable iff (!resetn_i || clear_i)
        push_i |-> !full_o);
`endif

endmodule

// File: rtl/ysyx_wbu_arb.sv
// rtl/ysyx_wbu_arb.sv - round-robin writeback arbiter over per-unit result FIFOs
module ysyx_wbu_arb
    import ysyx_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int DEPTH    = 2,
    parameter int ROB_SIZE = `YSYX_ROB_SIZE,
    parameter int PLEN     = `YSYX_PHY_LEN,
    parameter int XLEN     = `YSYX_XLEN,
    parameter int PKT_W    = wb_pkt_width(ROB_SIZE, PLEN, XLEN),
    parameter int SW       = $clog2(NREQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*PKT_W-1:0]   req_pkt,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [PKT_W-1:0]        wb_pkt,
    output logic [SW-1:0]           wb_src
);

    wb_pkt_t              in_pkt [NREQ];
    wb_pkt_t              head   [NREQ];
    logic [NREQ-1:0]      push, pop, full, empty;
    logic [SW-1:0]        rr_q, rr_d;
    logic                 hold_q, hold_d;
    logic [SW-1:0]        hold_src_q, hold_src_d;
    logic [SW-1:0]        scan_grant, grant;
    logic                 found;
    int                   idx;

    for (genvar i = 0; i < NREQ; i++) begin : g_fifo
        assign in_pkt[i]    = req_pkt[i*PKT_W +: PKT_W];
        assign req_ready[i] = !full[i];
        assign push[i]      = req_valid[i] && req_ready[i];
        assign pop[i]       = wb_valid && wb_ready && (grant == SW'(i));

        ysyx_wbu_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clock_i  (clock),
            .resetn_i (reset),
            .clear_i  (flush),
            .push_i   (push[i]),
            .pkt_i    (in_pkt[i]),
            .pop_i    (pop[i]),
            .head_o   (head[i]),
            .full_o   (full[i]),
            .empty_o  (empty[i]),
            .count_o  ()
        );

`ifndef SYNTHESIS
        a_dest_nonzero: assert property (@(posedge clock) disable iff (!reset || flush)
            push[i] |-> (in_pkt[i].dest != '0));
`endif
    end

    // Priority scan from rr_q upward, wrapping modulo NREQ.
    always_comb begin
        scan_grant = '0;
        found      = 1'b0;
        idx        = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && !empty[idx]) begin
                found      = 1'b1;
                scan_grant = SW'(idx);
            end
        end
    end

    // A stalled grant is frozen so a newly filled FIFO cannot steal the port.
    assign grant    = hold_q ? hold_src_q : scan_grant;
    assign wb_valid = |(~empty);
    assign wb_src   = wb_valid ? grant : '0;
    assign wb_pkt   = wb_valid ? head[grant] : '0;

    // Round-robin pointer and stall-hold next-state.
    always_comb begin
        rr_d       = rr_q;
        hold_d     = wb_valid && !wb_ready;
        hold_src_d = grant;
        if (wb_valid && wb_ready) begin
            rr_d = (grant == SW'(NREQ - 1)) ? '0 : grant + 1'b1;
        end
    end

    // Arbitration state; reset and flush both return to a clean, unheld rr_q = 0.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            rr_q       <= '0;
            hold_q     <= 1'b0;
            hold_src_q <= '0;
        end else begin
            rr_q       <= rr_d;
            hold_q     <= hold_d;
            hold_src_q <= hold_src_d;
        end
    end

endmodule
